// File: rtl/pci_xfer_phase_ctrl.sv
// pci_xfer_phase_ctrl
// PCI transfer-phase controller: decodes the C/BE command in the address
// phase, latches the master/target role, drives IRDY and C/BE as master,
// counts data phases against a bounded burst length and latches the byte
// enables of each completed phase.
// Optional build macro: PCI_DEVSEL_TIMEOUT_EN adds a master-abort timeout
// while waiting for devsel (DEVSEL_TO cycles).
module pci_xfer_phase_ctrl #(
    parameter int BE_W      = 4,
    parameter int CNT_W     = 4,
    parameter int MAX_BURST = 8,
    parameter int DEVSEL_TO = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_m,
    inout  wire  [BE_W-1:0]  c_be,
    input  logic [BE_W-1:0]  c_be_drv,
    input  logic             frame,
    input  logic             devsel,
    input  logic             trdy,
    input  logic [CNT_W-1:0] burst_len,
    output logic             irdy,
    output logic             r_w,
    output logic [CNT_W-1:0] data_count,
    output logic [BE_W-1:0]  be_latch,
    output logic             busy,
    output logic             stop,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DEVSEL,
        DATA,
        TURN
    } state_t;

    state_t           state;
    logic             role_q;
    logic             role_eff;
    logic [3:0]       cmd;
    logic             cmd_ok;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] burst_target;
    logic             irdy_eff;
    logic             phase_done;

`ifdef PCI_DEVSEL_TIMEOUT_EN
    localparam int TO_W = (DEVSEL_TO < 2) ? 1 : $clog2(DEVSEL_TO);
    logic [TO_W-1:0] to_cnt;
`else
    logic unused_devsel_to;
    assign unused_devsel_to = (DEVSEL_TO > 0);
`endif

    // The role used for the tristates follows s_m only while idle so a
    // transaction keeps the role it started with.
    assign role_eff = (state == IDLE) ? s_m : role_q;

    assign c_be = role_eff ? c_be_drv : {BE_W{1'bz}};
    assign irdy = role_eff ? (state == DATA) : 1'bz;

    // Supported commands are 0010, 0011, 0110 and 0111: bit 3 clear, bit 1 set.
    assign cmd    = c_be[3:0];
    assign cmd_ok = (cmd[3] == 1'b0) && (cmd[1] == 1'b1);

    assign count_next   = data_count + 1'b1;
    assign burst_target = (burst_len == '0) ? CNT_W'(1) : burst_len;

    // As target the initiator's readiness is inferred from frame, with the
    // first phase always considered ready.
    assign irdy_eff   = role_q ? 1'b1 : (frame || (data_count == '0));
    assign phase_done = irdy_eff && trdy;

    // Transaction state machine with registered status outputs and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            role_q     <= 1'b0;
            r_w        <= 1'b0;
            data_count <= '0;
            be_latch   <= '0;
            busy       <= 1'b0;
            stop       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef PCI_DEVSEL_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            stop <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame) begin
                        role_q     <= s_m;
                        r_w        <= s_m ? cmd[0] : ~cmd[0];
                        data_count <= '0;
                        busy       <= 1'b1;
`ifdef PCI_DEVSEL_TIMEOUT_EN
                        to_cnt     <= '0;
`endif
                        if (cmd_ok) begin
                            state <= WAIT_DEVSEL;
                        end else begin
                            err   <= 1'b1;
                            state <= TURN;
                        end
                    end
                end
                WAIT_DEVSEL: begin
                    if (devsel) begin
                        state <= DATA;
                    end else if (!frame) begin
                        state <= TURN;
`ifdef PCI_DEVSEL_TIMEOUT_EN
                    end else if (role_q && (to_cnt == TO_W'(DEVSEL_TO - 1))) begin
                        err   <= 1'b1;
                        state <= TURN;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                DATA: begin
                    if (!devsel) begin
                        state <= TURN;
                    end else if (phase_done) begin
                        data_count <= count_next;
                        be_latch   <= c_be;
                        if (role_q) begin
                            if (count_next == burst_target) begin
                                state <= TURN;
                            end
                        end else if (count_next == CNT_W'(MAX_BURST)) begin
                            stop  <= 1'b1;
                            state <= TURN;
                        end else if (!frame) begin
                            state <= TURN;
                        end
                    end
                end
                TURN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pci_xfer_phase_ctrl.sv
// tb_pci_xfer_phase_ctrl
// Directed bench for pci_xfer_phase_ctrl. A pull-up on irdy makes the
// high-Z target state read as 1, distinct from the driven-low master idle.
module tb_pci_xfer_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_m;
    logic [3:0] c_be_drv;
    logic       frame;
    logic       devsel;
    logic       trdy;
    logic [3:0] burst_len;
    logic       tb_cbe_en;
    logic [3:0] tb_cbe;
    wire  [3:0] c_be;
    wire        irdy;
    logic       r_w;
    logic [3:0] data_count;
    logic [3:0] be_latch;
    logic       busy;
    logic       stop;
    logic       done;
    logic       err;

    int compared   = 0;
    int mismatched = 0;

    assign c_be = tb_cbe_en ? tb_cbe : 4'bzzzz;
    pullup (irdy);

    always #5 clk = ~clk;

    pci_xfer_phase_ctrl #(
        .BE_W(4), .CNT_W(4), .MAX_BURST(8), .DEVSEL_TO(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_m(s_m), .c_be(c_be), .c_be_drv(c_be_drv),
        .frame(frame), .devsel(devsel), .trdy(trdy), .burst_len(burst_len),
        .irdy(irdy), .r_w(r_w), .data_count(data_count), .be_latch(be_latch),
        .busy(busy), .stop(stop), .done(done), .err(err)
    );

    // Drive the handshake inputs together.
    task automatic applyStimulus(input logic sm, input logic fr, input logic dv, input logic tr);
        s_m    = sm;
        frame  = fr;
        devsel = dv;
        trdy   = tr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; burst_len = 4'd0; c_be_drv = 4'h0; tb_cbe_en = 1'b0; tb_cbe = 4'h0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("rst_r_w", r_w, 0);
        checkOutput("rst_count", data_count, 0);
        checkOutput("rst_be", be_latch, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_stop", stop, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_irdy_tgt_z", irdy, 1);
        s_m = 1'b1; c_be_drv = 4'h3;
        #1;
        checkOutput("rst_irdy_mst", irdy, 0);
        checkOutput("rst_cbe_mst", c_be, 4'h3);
        tick(); tick();
        rst_n = 1'b1;

        $display("[TB] master IO write, burst 3");
        burst_len = 4'd3;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("m1_busy", busy, 1);
        checkOutput("m1_r_w", r_w, 1);
        checkOutput("m1_irdy_wait", irdy, 0);
        devsel = 1'b1;
        tick();
        checkOutput("m1_irdy_p1", irdy, 1);
        checkOutput("m1_count0", data_count, 0);
        c_be_drv = 4'h5;
        tick();
        checkOutput("m1_count1", data_count, 1);
        checkOutput("m1_be1", be_latch, 4'h5);
        checkOutput("m1_irdy_p2", irdy, 1);
        s_m = 1'b0;
        tick();
        checkOutput("m1_count2", data_count, 2);
        checkOutput("m1_irdy_p3", irdy, 1);
        checkOutput("m1_cbe_role_held", c_be, 4'h5);
        c_be_drv = 4'hC;
        tick();
        checkOutput("m1_count3", data_count, 3);
        checkOutput("m1_be3", be_latch, 4'hC);
        checkOutput("m1_irdy_turn", irdy, 0);
        checkOutput("m1_done_turn", done, 0);
        s_m = 1'b1; frame = 1'b0;
        tick();
        checkOutput("m1_done", done, 1);
        checkOutput("m1_busy_end", busy, 0);
        checkOutput("m1_count_hold", data_count, 3);
        tick();
        checkOutput("m1_done_once", done, 0);

        $display("[TB] target mem read, frame drop stalls, devsel ends");
        tb_cbe_en = 1'b1; tb_cbe = 4'h6;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("t1_r_w", r_w, 1);
        checkOutput("t1_irdy_z", irdy, 1);
        tick();
        tb_cbe = 4'h3;
        tick();
        checkOutput("t1_count1", data_count, 1);
        checkOutput("t1_be1", be_latch, 4'h3);
        tb_cbe = 4'h9;
        tick();
        checkOutput("t1_count2", data_count, 2);
        checkOutput("t1_be2", be_latch, 4'h9);
        frame = 1'b0; tb_cbe = 4'hF;
        tick();
        checkOutput("t1_stall_count", data_count, 2);
        checkOutput("t1_stall_be", be_latch, 4'h9);
        devsel = 1'b0;
        tick();
        checkOutput("t1_devsel_count", data_count, 2);
        checkOutput("t1_turn_done", done, 0);
        tick();
        checkOutput("t1_done", done, 1);
        checkOutput("t1_stop", stop, 0);
        checkOutput("t1_busy_end", busy, 0);

        $display("[TB] target single-phase mem write, frame exit");
        tb_cbe = 4'h7; frame = 1'b1; devsel = 1'b1;
        tick();
        checkOutput("t2_r_w", r_w, 0);
        checkOutput("t2_count_clr", data_count, 0);
        frame = 1'b0;
        tick();
        tb_cbe = 4'h6;
        tick();
        checkOutput("t2_count", data_count, 1);
        checkOutput("t2_be", be_latch, 4'h6);
        tick();
        checkOutput("t2_done", done, 1);

        $display("[TB] target disconnect at MAX_BURST");
        tb_cbe = 4'h6; frame = 1'b1; devsel = 1'b1; trdy = 1'b1;
        tick(); tick();
        for (int i = 1; i <= 7; i++) begin
            tick();
            checkOutput("t3_count", data_count, i);
            checkOutput("t3_no_stop", stop, 0);
        end
        tick();
        checkOutput("t3_count8", data_count, 8);
        checkOutput("t3_stop", stop, 1);
        tick();
        checkOutput("t3_done", done, 1);
        checkOutput("t3_stop_once", stop, 0);
        checkOutput("t3_turn_ignores_frame", busy, 0);
        tick();
        checkOutput("t3_new_cmd", busy, 1);
        checkOutput("t3_new_count", data_count, 0);
        frame = 1'b0; devsel = 1'b0;
        tick();
        checkOutput("t3_abort_err", err, 0);
        checkOutput("t3_abort_busy", busy, 1);
        tick();
        checkOutput("t3_abort_done", done, 1);

        $display("[TB] unsupported command");
        tb_cbe = 4'hA; frame = 1'b1; devsel = 1'b1; trdy = 1'b1;
        tick();
        checkOutput("u_err", err, 1);
        checkOutput("u_done_apart", done, 0);
        checkOutput("u_count", data_count, 0);
        frame = 1'b0;
        tick();
        checkOutput("u_done", done, 1);
        checkOutput("u_err_once", err, 0);
        checkOutput("u_no_data", data_count, 0);

        $display("[TB] master wait states then reset mid-DATA");
        tb_cbe_en = 1'b0; c_be_drv = 4'h7; burst_len = 4'd2;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("w_r_w", r_w, 1);
        tick();
        trdy = 1'b1;
        tick();
        checkOutput("w_count1", data_count, 1);
        trdy = 1'b0;
        tick();
        checkOutput("w_wait_count", data_count, 1);
        checkOutput("w_irdy", irdy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("w_rst_busy", busy, 0);
        checkOutput("w_rst_count", data_count, 0);
        checkOutput("w_rst_be", be_latch, 0);
        checkOutput("w_rst_r_w", r_w, 0);
        checkOutput("w_rst_irdy_mst", irdy, 0);
        s_m = 1'b0;
        #1;
        checkOutput("w_rst_irdy_tgt", irdy, 1);
        frame = 1'b0;
        tick();
        rst_n = 1'b1;

        $display("[TB] master IO read, burst_len 0");
        c_be_drv = 4'h2; burst_len = 4'd0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("b0_r_w", r_w, 0);
        tick();
        tick();
        checkOutput("b0_wait", data_count, 0);
        trdy = 1'b1;
        tick();
        checkOutput("b0_count", data_count, 1);
        checkOutput("b0_irdy_turn", irdy, 0);
        frame = 1'b0;
        tick();
        checkOutput("b0_done", done, 1);
        checkOutput("b0_count_hold", data_count, 1);

`ifdef PCI_DEVSEL_TIMEOUT_EN
        $display("[TB] master abort on devsel timeout");
        c_be_drv = 4'h3; burst_len = 4'd1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("to_no_err", err, 0);
        end
        tick();
        checkOutput("to_err", err, 1);
        frame = 1'b0;
        tick();
        checkOutput("to_done", done, 1);
        checkOutput("to_idle", busy, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pci_xfer_phase_ctrl.md
Name: pci_xfer_phase_ctrl

Overview:
- Parametrised successor to the PCI command/handshake decoder.
- Decodes the C/BE command in the address phase and latches the master/target role.
- Drives IRDY and C/BE when master, counts data phases with a bounded burst length, and latches per-phase byte enables.
- Sits between the PCI pin interface and the data-path FIFO control, in both master and target builds.

Parameters:
- BE_W, 4, C/BE width: 4 for 32-bit, 8 for 64-bit. The command is always in bits [3:0].
- CNT_W, 4, width of the data-phase counter and burst_len.
- MAX_BURST, 8, target-side disconnect limit in data phases (1..2^CNT_W-1).
- DEVSEL_TO, 5, master-abort timeout in cycles waiting for devsel (compiled only with the macro).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- s_m  in  1  role select: 1 = master, 0 = target
- c_be  inout  BE_W  command/byte-enable bus
- c_be_drv  in  BE_W  value the master drives onto c_be
- frame  in  1  transaction active, active-high
- devsel  in  1  target claimed, active-high
- trdy  in  1  target ready, active-high
- burst_len  in  CNT_W  master-requested data phases
- irdy  out  1  initiator ready; high-Z when role is target
- r_w  out  1  1 = this side sources data
- data_count  out  CNT_W  completed data phases
- be_latch  out  BE_W  byte enables of the last completed phase
- busy  out  1  transaction in progress
- stop  out  1  one-cycle target disconnect pulse
- done  out  1  one-cycle end-of-transaction pulse
- err  out  1  one-cycle unsupported-command / master-abort pulse

Behaviour:
- Reset values (asynchronous): state IDLE; r_w=0, data_count=0, be_latch=0, busy=0, stop=0, done=0, err=0, role_q=0.
- Tristate:
  - c_be = c_be_drv when the effective role is 1, else high-Z.
  - irdy is driven when the effective role is 1, else high-Z.
  - Effective role is s_m in IDLE and role_q otherwise.
- Supported commands (c_be[3:0]): 0010 IO read, 0011 IO write, 0110 mem read, 0111 mem write. Bit 0 = 1 means a write.
- r_w:
  - Master: r_w = write bit.
  - Target: r_w = inverted write bit.
  - Set on the IDLE exit edge; held until the next command.
- States: IDLE, WAIT_DEVSEL, DATA, TURN.
- IDLE:
  - On a clock with frame=1: latch role_q=s_m, decode c_be[3:0], clear data_count, set busy=1.
  - Supported command: go to WAIT_DEVSEL.
  - Unsupported command: pulse err, go to TURN.
- WAIT_DEVSEL:
  - devsel=1 goes to DATA next cycle.
  - frame=0 before devsel goes to TURN with no err.
- DATA:
  - irdy=1 when the role is master; irdy=0 in every other state.
  - A data phase completes on a clock where irdy_eff && trdy. irdy_eff is irdy for a master; for a target it is frame||(data_count==0).
  - Each completed phase: data_count+1; be_latch <= c_be (full BE_W) sampled that cycle.
  - Master exit: completing phase where data_count+1 == max(burst_len,1) goes to TURN. burst_len=0 is treated as 1.
  - Target exit: frame=0 on a completing phase goes to TURN. Reaching MAX_BURST completed phases pulses stop in that same cycle and goes to TURN.
  - devsel dropping to 0 in DATA goes to TURN immediately. Count is kept; no err.
- TURN:
  - Exactly one cycle: done=1, busy=0 on exit, then IDLE.
  - frame=1 during TURN is ignored; a new command is sampled no earlier than the following cycle.
- Simultaneous events:
  - stop and a frame=0 exit in the same cycle: stop still pulses.
  - err and done never overlap in a cycle.
- data_count holds its final value until the next IDLE exit and never wraps; MAX_BURST bounds it.
- s_m changes during a transaction have no effect until IDLE.
- rst_n low mid-transaction: immediate return to IDLE with reset values; tristates follow s_m.

Optional Feature:
- PCI_DEVSEL_TIMEOUT_EN defined: a counter runs in WAIT_DEVSEL. After DEVSEL_TO cycles with devsel=0 and role_q=1: pulse err, go to TURN (master abort). Target role is unaffected.
- Undefined: WAIT_DEVSEL waits indefinitely for devsel or frame=0; no timeout logic is built.

Test Plan:
- Master IO write: s_m=1, frame=1, c_be_drv=0011, burst_len=3, devsel next cycle, trdy=1 → r_w=1, irdy=1 for 3 cycles, data_count=3, done pulse, c_be driven throughout.
- Target mem read: s_m=0, c_be=0110, devsel=1, trdy=1, frame deasserted on the 2nd phase → r_w=1, irdy high-Z, data_count=2, done one cycle later.
- Target disconnect: MAX_BURST=8, frame held 1, trdy=1 → stop pulse on the 8th phase, data_count=8, TURN, then IDLE.
- Unsupported command: c_be=1010 with frame=1 → err pulse, data_count=0, done the next cycle, no DATA state.
- Wait states and reset: trdy toggling 1,0,1,0 with burst_len=2 → count increments only on trdy=1 cycles; rst_n=0 mid-DATA → all outputs at reset values immediately.
- With PCI_DEVSEL_TIMEOUT_EN, DEVSEL_TO=5, master, devsel stuck 0 → err after 5 cycles, then done, then IDLE.
